approx_adder_err_sweep_ctrl: RTL
================================

Name: approx_adder_err_sweep_ctrl

Overview:
Sequencer that drives an external combinational approximate adder with a stream of operand pairs. It computes the exact sum internally and accumulates error statistics for one characterization run: error count, sum of absolute error (for MAE) and maximum absolute error with its operands. It sits beside any `WIDTH`-bit approximate ripple-carry adder in the characterization harness; the adder itself is outside this block.

Parameters:
- `WIDTH`, 16, operand width; legal range 4..16 (LFSR operands come from one 32-bit register).
- `CNT_W`, 16, width of `n_samples` and `err_count`.
- `ACC_W`, `WIDTH+1+CNT_W`, width of `sum_abs_err`; cannot overflow within one run.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that begins a run; ignored while `busy`=1.
- `mode`  in  1  0 = counter sweep, 1 = LFSR random; sampled on accepted `start`.
- `seed`  in  32  initial generator state; sampled on accepted `start`.
- `n_samples`  in  `CNT_W`  number of pairs to issue; sampled on accepted `start`.
- `op_a`  out  `WIDTH`  operand A to adder (registered).
- `op_b`  out  `WIDTH`  operand B to adder (registered).
- `op_valid`  out  1  `op_a`/`op_b` hold a live sample this cycle.
- `approx_sum`  in  `WIDTH+1`  combinational adder result for the current `op_a`/`op_b`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when statistics are final.
- `err_count`  out  `CNT_W`  number of samples with `approx_sum` != exact.
- `sum_abs_err`  out  `ACC_W`  sum of |exact − approx|.
- `max_abs_err`  out  `WIDTH+1`  largest |exact − approx|.
- `max_a`, `max_b`  out  `WIDTH` each  operands of the first sample reaching `max_abs_err`.

Behaviour:
- Reset (async, `rst_n`=0): all outputs 0, FSM in IDLE, generator cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DRAIN when the last pair is issued.
  - DRAIN lasts 2 cycles → DONE.
  - DONE lasts 1 cycle with `done`=1, then → IDLE.
- Accepted `start`:
  - clears `err_count`, `sum_abs_err`, `max_abs_err`, `max_a`, `max_b`;
  - loads the generator and loads the remaining-count register from `n_samples`.
- `n_samples`=0: RUN issues nothing. The FSM goes straight to DRAIN, and `done` pulses 3 cycles after `start` with all statistics 0.
- Generator, advanced once per issued pair:
  - Counter mode: 32-bit register `g` starts at `seed`, increments by 1 modulo 2^32.
  - LFSR mode: 32-bit Galois LFSR, taps mask 0x80200003, shift right. A `seed` of 0 is replaced by 0xFFFFFFFF.
  - Operand mapping: `op_a` = `g[WIDTH+15:16]`, `op_b` = `g[WIDTH-1:0]`.
- Issue timing: in RUN, `op_valid`=1 every cycle for exactly `n_samples` consecutive cycles, with the first pair in the cycle after `start`. Outside RUN, `op_valid`=0 and `op_a`/`op_b` hold their last values.
- Pipeline, 2 stages:
  - Stage 1, at the edge where `op_valid`=1: capture `exact` = `op_a`+`op_b` (`WIDTH+1` bits), `approx_sum`, and the operands.
  - Stage 2: `abs_err` = |exact − approx| computed in `WIDTH+2`-bit signed arithmetic, result `WIDTH+1` bits unsigned. Register it with a valid bit.
  - Stage 3 (accumulate): if `abs_err` != 0, increment `err_count`. Add `abs_err` to `sum_abs_err`. If `abs_err` > `max_abs_err` (strictly), update the max and its operands, so ties keep the earliest sample.
- Statistics are final and stable when `done` pulses, and hold until the next accepted `start`.
- `start` during RUN, DRAIN or DONE is ignored; there is no queueing.
- `rst_n` asserted mid-run aborts immediately to reset values; no `done` pulse follows.
- The counter wraps from 0xFFFFFFFF to 0 silently.

Test Plan:
1. Counter mode, `seed`=0, `n_samples`=1, adder = 16-bit RC with lower 11 stages approximate (S=0, Cout=~Cin) → pair (0,0), approx 0x00800, `err_count`=1, `sum_abs_err`=2048, `max_abs_err`=2048, `max_a`=`max_b`=0; `done` 4 cycles after `start`.
2. Exact adder model, LFSR mode, `seed`=0x12345678, `n_samples`=1000 → `err_count`=0, `sum_abs_err`=0, `max_abs_err`=0, `op_valid` high exactly 1000 cycles.
3. `n_samples`=0 → no `op_valid`; `done` 3 cycles after `start`; all statistics 0.
4. Counter mode, `seed`=0xFFFFFFFE, `n_samples`=3 → issued pairs (0xFFFF,0xFFFE), (0xFFFF,0xFFFF), (0,0): verifies wrap and operand mapping.
5. Second `start` pulsed mid-RUN → ignored, counts unchanged; then `rst_n` low mid-run → all outputs 0 next cycle, no `done`.
6. Adder stub that returns exact−5 on two samples → `max_a`/`max_b` equal the first such sample; `err_count`=2, `sum_abs_err`=10.

Source files
------------

// File: rtl/approx_adder_err_sweep_ctrl.sv
// Operand sequencer and error-statistics collector for characterizing an external
// approximate adder: issues counter/LFSR operand pairs and accumulates error count, sum and max.
module approx_adder_err_sweep_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16,
  parameter int ACC_W = WIDTH + 1 + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] n_samples,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_valid,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [WIDTH:0]   max_abs_err,
  output logic [WIDTH-1:0] max_a,
  output logic [WIDTH-1:0] max_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  state_t           state_q, state_d;
  logic             drain_q, drain_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [31:0]      g_q, g_d, g_adv, seed_eff;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             clear;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH:0]   s1_exact_q, s1_exact_d, s1_approx_q, s1_approx_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH:0]   s2_abs_q, s2_abs_d;
  logic [WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic signed [WIDTH+1:0] diff, diff_neg;

  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_abs_err_q, sum_abs_err_d;
  logic [WIDTH:0]   max_abs_err_q, max_abs_err_d;
  logic [WIDTH-1:0] max_a_q, max_a_d, max_b_q, max_b_d;

  // An all-zero LFSR state would lock up, so a zero seed is swapped for all ones.
  assign seed_eff = (mode && (seed == 32'h0)) ? 32'hFFFF_FFFF : seed;
  assign g_adv    = mode_q ? ({1'b0, g_q[31:1]} ^ (g_q[0] ? LFSR_TAPS : 32'h0))
                           : (g_q + 32'd1);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    g_d     = g_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          mode_d  = mode;
          rem_d   = n_samples;
          g_d     = seed_eff;
          drain_d = 1'b0;
          if (n_samples == '0) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
            op_a_d  = seed_eff[WIDTH+15:16];
            op_b_d  = seed_eff[WIDTH-1:0];
          end
        end
      end
      RUN: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          g_d    = g_adv;
          op_a_d = g_adv[WIDTH+15:16];
          op_b_d = g_adv[WIDTH-1:0];
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign op_valid = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  // Difference is formed one bit wider than the sum so its sign is never lost.
  assign diff     = $signed({1'b0, s1_exact_q}) - $signed({1'b0, s1_approx_q});
  assign diff_neg = -diff;

  always_comb begin
    s1_valid_d  = op_valid;
    s1_exact_d  = s1_exact_q;
    s1_approx_d = s1_approx_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    if (op_valid) begin
      s1_exact_d  = {1'b0, op_a_q} + {1'b0, op_b_q};
      s1_approx_d = approx_sum;
      s1_a_d      = op_a_q;
      s1_b_d      = op_b_q;
    end
    s2_valid_d = s1_valid_q;
    s2_abs_d   = diff[WIDTH+1] ? diff_neg[WIDTH:0] : diff[WIDTH:0];
    s2_a_d     = s1_a_q;
    s2_b_d     = s1_b_q;
  end

  // Strict greater-than keeps the earliest sample on ties.
  always_comb begin
    err_count_d   = err_count_q;
    sum_abs_err_d = sum_abs_err_q;
    max_abs_err_d = max_abs_err_q;
    max_a_d       = max_a_q;
    max_b_d       = max_b_q;
    if (clear) begin
      err_count_d   = '0;
      sum_abs_err_d = '0;
      max_abs_err_d = '0;
      max_a_d       = '0;
      max_b_d       = '0;
    end else if (s2_valid_q) begin
      if (s2_abs_q != '0) err_count_d = err_count_q + CNT_W'(1);
      sum_abs_err_d = sum_abs_err_q + ACC_W'(s2_abs_q);
      if (s2_abs_q > max_abs_err_q) begin
        max_abs_err_d = s2_abs_q;
        max_a_d       = s2_a_q;
        max_b_d       = s2_b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      drain_q       <= 1'b0;
      mode_q        <= 1'b0;
      rem_q         <= '0;
      g_q           <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_exact_q    <= '0;
      s1_approx_q   <= '0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s2_valid_q    <= 1'b0;
      s2_abs_q      <= '0;
      s2_a_q        <= '0;
      s2_b_q        <= '0;
      err_count_q   <= '0;
      sum_abs_err_q <= '0;
      max_abs_err_q <= '0;
      max_a_q       <= '0;
      max_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      mode_q        <= mode_d;
      rem_q         <= rem_d;
      g_q           <= g_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      s1_valid_q    <= s1_valid_d;
      s1_exact_q    <= s1_exact_d;
      s1_approx_q   <= s1_approx_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s2_valid_q    <= s2_valid_d;
      s2_abs_q      <= s2_abs_d;
      s2_a_q        <= s2_a_d;
      s2_b_q        <= s2_b_d;
      err_count_q   <= err_count_d;
      sum_abs_err_q <= sum_abs_err_d;
      max_abs_err_q <= max_abs_err_d;
      max_a_q       <= max_a_d;
      max_b_q       <= max_b_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign err_count   = err_count_q;
  assign sum_abs_err = sum_abs_err_q;
  assign max_abs_err = max_abs_err_q;
  assign max_a       = max_a_q;
  assign max_b       = max_b_q;

endmodule
